// File: rtl/lsu_mem_port.sv
// Memory-stage load/store port: issues one word access per request on a req/ack bus,
// stalls the pipeline while it is outstanding and registers load words for the align stage.
module lsu_mem_port #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_M,
  input  logic        mem_write_M,
  input  logic [31:0] addr_M,
  input  logic [31:0] wdata_M,
  input  logic [2:0]  load_sel_M,
  input  logic [1:0]  store_sel_M,
  output logic        stall_M,
  output logic        misalign_M,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        bus_err,
  output logic [31:0] rdata_W,
  output logic [1:0]  offset_W,
  output logic [2:0]  load_sel_W,
  output logic        rdata_valid_W
);

  // Bus handshake: bus_req rises the cycle after acceptance and holds with all bus
  // outputs constant until the first cycle bus_ack is high; that cycle completes the access.
  typedef enum logic {IDLE, BUSY} state_e;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  lsel_q, lsel_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  off_w_q, off_w_d;
  logic [2:0]  lsel_w_q, lsel_w_d;
  logic        valid_q, valid_d;

  logic        access;
  logic        timeout_hit;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata;

  // Load codes other than byte (x00) and half (x01) behave as word.
  always_comb begin
    misalign_M = 1'b0;
    if (state_q == IDLE) begin
      if (mem_write_M) begin
        case (store_sel_M)
          2'b00:   misalign_M = 1'b0;
          2'b01:   misalign_M = addr_M[0];
          default: misalign_M = |addr_M[1:0];
        endcase
      end else if (mem_read_M) begin
        case (load_sel_M[1:0])
          2'b00:   misalign_M = 1'b0;
          2'b01:   misalign_M = addr_M[0];
          default: misalign_M = |addr_M[1:0];
        endcase
      end
    end
  end

  assign access      = (state_q == IDLE) & (mem_read_M | mem_write_M) & ~misalign_M;
  assign timeout_hit = (state_q == BUSY) & ~bus_ack & (cnt_q == 8'(TIMEOUT - 1));
  assign stall_M     = access | ((state_q == BUSY) & ~bus_ack & ~timeout_hit);

  always_comb begin
    fmt_be    = 4'b1111;
    fmt_wdata = 32'h0;
    if (mem_write_M) begin
      case (store_sel_M)
        2'b00: begin
          fmt_be    = 4'b0001 << addr_M[1:0];
          fmt_wdata = {4{wdata_M[7:0]}};
        end
        2'b01: begin
          fmt_be    = addr_M[1] ? 4'b1100 : 4'b0011;
          fmt_wdata = {2{wdata_M[15:0]}};
        end
        default: begin
          fmt_be    = 4'b1111;
          fmt_wdata = wdata_M;
        end
      endcase
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    off_d    = off_q;
    lsel_d   = lsel_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdata_d  = rdata_q;
    off_w_d  = off_w_q;
    lsel_w_d = lsel_w_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          we_d    = mem_write_M;
          addr_d  = {addr_M[31:2], 2'b00};
          be_d    = fmt_be;
          wdata_d = fmt_wdata;
          off_d   = addr_M[1:0];
          lsel_d  = load_sel_M;
          cnt_d   = 8'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack) begin
          if (!we_q) begin
            rdata_d  = bus_rdata;
            off_w_d  = off_q;
            lsel_w_d = lsel_q;
            valid_d  = 1'b1;
          end
          state_d = IDLE;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= 32'h0;
      be_q     <= 4'h0;
      wdata_q  <= 32'h0;
      off_q    <= 2'b00;
      lsel_q   <= 3'b000;
      cnt_q    <= 8'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'h0;
      off_w_q  <= 2'b00;
      lsel_w_q <= 3'b000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      be_q     <= be_d;
      wdata_q  <= wdata_d;
      off_q    <= off_d;
      lsel_q   <= lsel_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      off_w_q  <= off_w_d;
      lsel_w_q <= lsel_w_d;
      valid_q  <= valid_d;
    end
  end

  // bus_req is decoded from state so an asynchronous reset drops it immediately.
  assign bus_req       = (state_q == BUSY);
  assign bus_we        = we_q;
  assign bus_addr      = addr_q;
  assign bus_be        = be_q;
  assign bus_wdata     = wdata_q;
  assign bus_err       = err_q;
  assign rdata_W       = rdata_q;
  assign offset_W      = off_w_q;
  assign load_sel_W    = lsel_w_q;
  assign rdata_valid_W = valid_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: table of single accesses plus timeout, reset and random load
// sequences; completed loads are checked against an expected queue.
module tb_lsu_mem_port;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read_M = 1'b0;
  logic        mem_write_M = 1'b0;
  logic [31:0] addr_M = '0;
  logic [31:0] wdata_M = '0;
  logic [2:0]  load_sel_M = '0;
  logic [1:0]  store_sel_M = '0;
  logic        stall_M, misalign_M, bus_req, bus_we, bus_err, rdata_valid_W;
  logic [31:0] bus_addr, bus_wdata, rdata_W;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  offset_W;
  logic [2:0]  load_sel_W;

  lsu_mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_M(mem_read_M), .mem_write_M(mem_write_M),
    .addr_M(addr_M), .wdata_M(wdata_M),
    .load_sel_M(load_sel_M), .store_sel_M(store_sel_M),
    .stall_M(stall_M), .misalign_M(misalign_M),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .rdata_W(rdata_W), .offset_W(offset_W), .load_sel_W(load_sel_W),
    .rdata_valid_W(rdata_valid_W)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  lsel;
    logic [1:0]  ssel;
    int          waits;
    logic [31:0] rdata;
    logic        mis;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wd;
  } vec_t;

  vec_t        tbl[13];
  logic [36:0] exp_q[$];   // {rdata, offset, load_sel}
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic rd, logic wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [2:0] lsel, logic [1:0] ssel, int waits, logic [31:0] rdata,
                              logic mis, logic we, logic [3:0] be, logic [31:0] wd);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.lsel = lsel; v.ssel = ssel;
    v.waits = waits; v.rdata = rdata; v.mis = mis; v.we = we; v.be = be; v.wd = wd;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mem_read_M = v.rd; mem_write_M = v.wr; addr_M = v.addr; wdata_M = v.wdata;
    load_sel_M = v.lsel; store_sel_M = v.ssel;
  endtask

  task automatic clear_in();
    mem_read_M = 1'b0; mem_write_M = 1'b0;
  endtask

  task automatic check_bus(input vec_t v, input string tag);
    chk({tag, "_req"}, 64'(bus_req), 64'd1);
    chk({tag, "_addr"}, 64'(bus_addr), 64'({v.addr[31:2], 2'b00}));
    chk({tag, "_we"}, 64'(bus_we), 64'(v.we));
    chk({tag, "_be"}, 64'(bus_be), 64'(v.be));
    if (v.we) chk({tag, "_wdata"}, 64'(bus_wdata), 64'(v.wd));
  endtask

  task automatic run_vec(input vec_t v);
    logic is_load;
    is_load = v.rd & ~v.wr;
    @(negedge clk);
    drive(v);
    #1;
    chk("misalign", 64'(misalign_M), 64'(v.mis));
    chk("stall_accept", 64'(stall_M), 64'(!v.mis));
    if (v.mis) begin
      @(negedge clk);
      chk("mis_no_req", 64'(bus_req), 64'd0);
      clear_in();
      return;
    end
    if (is_load) exp_q.push_back({v.rdata, v.addr[1:0], v.lsel});
    @(negedge clk);
    check_bus(v, "busy");
    for (int w = 0; w < v.waits; w++) begin
      bus_ack = 1'b0;
      #1;
      chk("stall_wait", 64'(stall_M), 64'd1);
      check_bus(v, "wait");
      @(negedge clk);
    end
    bus_ack = 1'b1;
    bus_rdata = v.rdata;
    #1;
    chk("stall_ack", 64'(stall_M), 64'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    bus_rdata = 32'h5A5A_0F0F;
    clear_in();
    #1;
    chk("req_drop", 64'(bus_req), 64'd0);
    chk("valid_pulse", 64'(rdata_valid_W), 64'(is_load));
    if (rdata_valid_W) begin
      if (exp_q.size() == 0) chk("sb_empty", 64'd1, 64'd0);
      else chk("sb_load", 64'({rdata_W, offset_W, load_sel_W}), 64'(exp_q.pop_front()));
      last_rdata = v.rdata;
    end else begin
      chk("retain", 64'(rdata_W), 64'(last_rdata));
    end
    // Stray ack while idle must not start or complete anything.
    bus_ack = 1'b1;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    chk("idle_ack_req", 64'(bus_req), 64'd0);
    chk("valid_one_cycle", 64'(rdata_valid_W), 64'd0);
    chk("no_err", 64'(bus_err), 64'd0);
  endtask

  initial begin
    tbl[0]  = mk(1, 0, 32'h100, 32'h0,        3'b010, 2'b00, 0, 32'hDEADBEEF, 0, 0, 4'b1111, 32'h0);
    tbl[1]  = mk(0, 1, 32'h203, 32'h0000_00A5, 3'b000, 2'b00, 0, 32'h0,       0, 1, 4'b1000, 32'hA5A5A5A5);
    tbl[2]  = mk(0, 1, 32'h202, 32'h0000_1234, 3'b000, 2'b01, 1, 32'h0,       0, 1, 4'b1100, 32'h12341234);
    tbl[3]  = mk(1, 0, 32'h301, 32'h0,        3'b100, 2'b00, 3, 32'h11223344, 0, 0, 4'b1111, 32'h0);
    tbl[4]  = mk(1, 0, 32'h102, 32'h0,        3'b010, 2'b00, 0, 32'h0,       1, 0, 4'b0000, 32'h0);
    tbl[5]  = mk(0, 1, 32'h105, 32'h0,        3'b000, 2'b01, 0, 32'h0,       1, 0, 4'b0000, 32'h0);
    tbl[6]  = mk(1, 1, 32'h400, 32'hCAFEF00D, 3'b010, 2'b10, 1, 32'h0,       0, 1, 4'b1111, 32'hCAFEF00D);
    tbl[7]  = mk(1, 0, 32'h206, 32'h0,        3'b001, 2'b00, 2, 32'h89ABCDEF, 0, 0, 4'b1111, 32'h0);
    tbl[8]  = mk(1, 0, 32'h203, 32'h0,        3'b101, 2'b00, 0, 32'h0,       1, 0, 4'b0000, 32'h0);
    tbl[9]  = mk(0, 1, 32'h101, 32'h1234_567E, 3'b000, 2'b00, 0, 32'h0,       0, 1, 4'b0010, 32'h7E7E7E7E);
    tbl[10] = mk(1, 0, 32'h103, 32'h0,        3'b000, 2'b00, 0, 32'h80000000, 0, 0, 4'b1111, 32'h0);
    tbl[11] = mk(0, 1, 32'h200, 32'hFFFF_5678, 3'b000, 2'b01, 0, 32'h0,       0, 1, 4'b0011, 32'h56785678);
    tbl[12] = mk(1, 0, 32'h102, 32'h0,        3'b111, 2'b00, 0, 32'h0,       1, 0, 4'b0000, 32'h0);

    // Reset state
    #12;
    chk("rst_outputs", 64'({bus_req, bus_we, bus_be, bus_err, offset_W, load_sel_W, rdata_valid_W,
                            stall_M, misalign_M}), 64'd0);
    chk("rst_addr", 64'({bus_addr, bus_wdata}), 64'd0);
    chk("rst_rdata", 64'(rdata_W), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Timeout: load with no ack
    begin
      vec_t v;
      v = mk(1, 0, 32'h600, 32'h0, 3'b010, 2'b00, 0, 32'h0, 0, 0, 4'b1111, 32'h0);
      @(negedge clk);
      drive(v);
      @(negedge clk);
      for (int i = 0; i < TO - 1; i++) begin
        #1;
        chk("to_stall", 64'(stall_M), 64'd1);
        chk("to_req", 64'(bus_req), 64'd1);
        chk("to_err_early", 64'(bus_err), 64'd0);
        @(negedge clk);
      end
      #1;
      chk("to_stall_release", 64'(stall_M), 64'd0);
      chk("to_err_not_yet", 64'(bus_err), 64'd0);
      @(negedge clk);
      clear_in();
      #1;
      chk("to_err", 64'(bus_err), 64'd1);
      chk("to_req_drop", 64'(bus_req), 64'd0);
      chk("to_no_valid", 64'(rdata_valid_W), 64'd0);
      chk("to_rdata_kept", 64'(rdata_W), 64'(last_rdata));
      @(negedge clk);
      chk("to_err_pulse", 64'(bus_err), 64'd0);
    end

    // Random aligned loads with random wait states
    for (int n = 0; n < 8; n++) begin
      vec_t v;
      int   w;
      w = $urandom_range(0, 3);
      v = mk(1, 0, 32'($urandom_range(0, 1023)) << 2, 32'h0, 3'b010, 2'b00, w,
             32'($urandom_range(0, 32'hFFFF_FFFF)), 0, 0, 4'b1111, 32'h0);
      run_vec(v);
    end

    // Reset in the middle of a store
    begin
      vec_t v;
      v = mk(0, 1, 32'h500, 32'h12345678, 3'b000, 2'b10, 0, 32'h0, 0, 1, 4'b1111, 32'h12345678);
      @(negedge clk);
      drive(v);
      @(negedge clk);
      check_bus(v, "pre_rst");
      rst_n = 1'b0;
      #1;
      chk("midrst_bus", 64'({bus_req, bus_we, bus_be, bus_err, offset_W, load_sel_W,
                             rdata_valid_W}), 64'd0);
      chk("midrst_addr", 64'({bus_addr, bus_wdata}), 64'd0);
      chk("midrst_rdata", 64'(rdata_W), 64'd0);
      clear_in();
      @(negedge clk);
      rst_n = 1'b1;
      last_rdata = 32'h0;
      @(negedge clk);
      chk("post_rst_err", 64'({bus_err, bus_req}), 64'd0);
    end

    run_vec(tbl[0]);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
